padded_column_streamer: RTL and testbench
=========================================

Name: padded_column_streamer

Overview:
- Reads one stored frame (IMG_H rows x IMG_W columns, raster order) from the input ping-pong buffer read port.
- Emits it column by column as a parallel vector to the PE array, with a runtime-selectable border of 0..PAD_MAX pad pixels of value pad_value on all four sides.
- Uses a valid/ready handshake toward the PE array.
- Returns the buffer half to the writer when the frame is done.

Parameters:
- IMG_W, 32, stored image width in pixels (columns).
- IMG_H, 32, stored image height in pixels (rows).
- DW, 8, pixel width in bits.
- PAD_MAX, 2, largest supported border width; sets the output vector size.
- AW, 16, buffer read address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- PEclk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes the FSM and issues no new reads.
- start  in  1  buffer-ready pulse; starts a frame when in IDLE.
- pad_len  in  2  border width; values above PAD_MAX are clamped to PAD_MAX.
- pad_value  in  DW  border pixel value.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  AW  read address = row*IMG_W + col.
- mem_rd_data  in  DW  read data, valid exactly 1 cycle after mem_rd_en.
- col_data  out  (IMG_H+2*PAD_MAX)*DW  column vector; lane k = bits [k*DW +: DW]; lane 0 is the top row.
- col_vld  out  1  col_data is valid.
- col_rdy  in  1  PE array accepts the column.
- col_idx  out  $clog2(IMG_W+2*PAD_MAX+1)  index of the presented output column.
- frame_last  out  1  the presented column is the final column of the frame.
- buf_release  out  1  one-cycle pulse that toggles the ping-pong buffer.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; col_data all zero; FSM in IDLE.
- Frame parameters:
  - pad_len is clamped to P and pad_value is captured into PV when start is accepted.
  - Changes to either input mid-frame have no effect.
- Output columns: NC = IMG_W + 2P, numbered c = 0..NC-1.
  - Columns c < P and c >= IMG_W+P are pad columns: every lane = PV.
  - Other columns are image columns with src = c - P:
    - lanes P .. P+IMG_H-1 = pixel (row = lane-P, col = src);
    - all other lanes = PV, including the unused top lanes when P < PAD_MAX.
- States:
  - IDLE: on start && en, latch P/PV, set c=0, go to LOAD. A start seen in any other state is ignored.
  - LOAD:
    - Pad column: preset all lanes to PV in one cycle, then go to SHOW.
    - Image column: preset all lanes to PV, then issue reads for row = 0..IMG_H-1 on consecutive en-high cycles (mem_rd_en=1). Each returned word is written into lane P+row one cycle later. After the last return, go to SHOW.
    - Latency for an image column: col_vld rises IMG_H+1 cycles after LOAD entry (no en stalls).
  - SHOW:
    - col_vld=1; col_data, col_idx and frame_last (= c==NC-1) are held stable until col_rdy.
    - On col_vld && col_rdy: if c==NC-1, go to REL; else c++ and go to LOAD. col_vld drops on the following cycle.
  - REL: buf_release=1 for exactly one cycle, then return to IDLE. busy falls on the same cycle as the return.
- en low:
  - FSM, counters and mem_rd_en hold (no read is issued).
  - A read issued the previous cycle is still captured; data capture is not gated by en.
  - In SHOW, col_vld stays asserted; the handshake is still honoured.
- Back-to-back: IDLE accepts a new start the cycle after REL. Minimum frame time = P pad columns*2 + IMG_W*(IMG_H+2) + ... cycles; no read/present overlap.
- Address arithmetic: computed as row*IMG_W + src in AW bits, with no wrap inside a frame.
- Reset mid-frame: immediate return to IDLE. Outputs go to reset values, no buf_release is pulsed, and a read in flight is discarded.

Decomposition:
- Shared package pe_pkg holds:
  - the state enum (IDLE, LOAD, SHOW, REL);
  - lane-count and column-count localparams derived from IMG_W/IMG_H/PAD_MAX;
  - the clamp function for pad_len.
- One sub-module, col_addr_gen: holds the row/column counters and generates mem_rd_addr and mem_rd_en, driven by LOAD and en. The FSM, lane capture and handshake stay in the top.

Test Plan:
- IMG_W=4, IMG_H=3, DW=8, PAD_MAX=2, memory word = address, pad_len=1, pad_value=0xEE, col_rdy=1:
  - 6 columns appear.
  - col 0 = all 0xEE.
  - col 1 lanes 0..6 = EE,00,04,08,EE,EE,EE.
  - col 5 = all 0xEE with frame_last=1.
  - buf_release pulses once, 1 cycle after the col 5 handshake.
- Same frame with pad_len=0:
  - 4 columns; col 0 lanes = 00,04,08,PV...; the first col_vld occurs 4 cycles after LOAD entry.
- pad_len=3 (clamp to 2): 8 columns; col 2 lanes 2..4 = 00,04,08.
- col_rdy low for 5 cycles in SHOW: col_vld, col_data and col_idx are held unchanged; no reads issue; exactly one transfer is counted.
- en low for 2 cycles in the middle of LOAD: the read sequence pauses, no address is skipped or duplicated, and the captured column is identical to the no-stall run.
- Negative cases:
  - rst_n asserted mid-frame returns all outputs to 0 with no buf_release pulse.
  - start asserted while busy is ignored: exactly one buf_release per accepted start.

Source files
------------

// File: rtl/padded_column_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and helpers for the padded column streamer:
//                FSM state encoding, lane/column count derivation and the
//                border-width clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam int c_img_w_def   = 32;
  localparam int c_img_h_def   = 32;
  localparam int c_pad_max_def = 2;

  // Output vector lanes: stored rows plus the widest border on top and bottom
  function automatic int lane_count(input int img_h, input int pad_max);
    return img_h + 2 * pad_max;
  endfunction

  // Largest number of output columns a frame can produce
  function automatic int col_count_max(input int img_w, input int pad_max);
    return img_w + 2 * pad_max;
  endfunction

  localparam int c_lanes_def = lane_count(c_img_h_def, c_pad_max_def);
  localparam int c_cols_def  = col_count_max(c_img_w_def, c_pad_max_def);

  // Border widths beyond what the output vector can hold saturate at pad_max
  function automatic logic [1:0] clamp_pad(input logic [1:0] len, input int pad_max);
    if (int'(len) > pad_max) return 2'(pad_max);
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/padded_column_streamer_col_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : col_addr_gen
//  Description : Output-column and source-row counters. Classifies the current
//                column as pad or image and issues one buffer read per stored
//                row while an image column is being loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module col_addr_gen #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = 16,
  parameter int CW    = 6,
  parameter int RW    = 6
) (
  input  logic          PEclk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [1:0]    p_i,
  input  logic          col_clr_i,
  input  logic          col_inc_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          is_img_o,
  output logic          last_col_o,
  output logic          rows_done_o,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_rd_addr_o
);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] w_p;
  logic [CW-1:0] w_src;

  assign w_p         = CW'(p_i);
  assign w_src       = col_q - w_p;
  assign is_img_o    = (col_q >= w_p) && (col_q < CW'(IMG_W) + w_p);
  assign last_col_o  = (col_q == CW'(IMG_W) + w_p + w_p - CW'(1));
  assign rows_done_o = (row_q == RW'(IMG_H));
  assign mem_rd_en_o = load_i && is_img_o && en_i && !rows_done_o;
  // Address is parked at zero whenever no read is being issued
  assign mem_rd_addr_o = mem_rd_en_o ? (AW'(row_q) * AW'(IMG_W) + AW'(w_src)) : '0;
  assign col_o       = col_q;
  assign row_o       = row_q;

  // Row counter: advances per issued read, rewinds whenever not loading an image column
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else if (!(load_i && is_img_o)) begin
      row_q <= '0;
    end else if (mem_rd_en_o) begin
      row_q <= row_q + RW'(1);
    end
  end

  // Output column counter: cleared at frame start, stepped on each non-final handshake
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else if (col_clr_i) begin
      col_q <= '0;
    end else if (col_inc_i) begin
      col_q <= col_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/padded_column_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : padded_column_streamer
//  Description : Streams a stored IMG_H x IMG_W frame to the PE array one
//                column at a time, wrapped in a runtime-selectable border of
//                pad pixels, then hands the ping-pong buffer half back.
//  Revision    : 1.0 - initial release
// ============================================================================
module padded_column_streamer
  import pe_pkg::*;
#(
  parameter int IMG_W   = c_img_w_def,
  parameter int IMG_H   = c_img_h_def,
  parameter int DW      = 8,
  parameter int PAD_MAX = c_pad_max_def,
  parameter int AW      = 16
) (
  input  logic                                  PEclk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  start,
  input  logic [1:0]                            pad_len,
  input  logic [DW-1:0]                         pad_value,
  output logic                                  mem_rd_en,
  output logic [AW-1:0]                         mem_rd_addr,
  input  logic [DW-1:0]                         mem_rd_data,
  output logic [(IMG_H+2*PAD_MAX)*DW-1:0]       col_data,
  output logic                                  col_vld,
  input  logic                                  col_rdy,
  output logic [$clog2(IMG_W+2*PAD_MAX+1)-1:0]  col_idx,
  output logic                                  frame_last,
  output logic                                  buf_release,
  output logic                                  busy
);

  localparam int c_lanes = lane_count(IMG_H, PAD_MAX);
  localparam int c_cw    = $clog2(col_count_max(IMG_W, PAD_MAX) + 1);
  localparam int c_rw    = $clog2(IMG_H + 1);
  localparam int c_lw    = $clog2(c_lanes);

  state_t                 state_q;
  logic [1:0]             p_q;
  logic [DW-1:0]          pv_q;
  logic [c_lanes*DW-1:0]  col_data_q;
  logic                   col_vld_q;
  logic                   frame_last_q;
  logic                   buf_release_q;
  logic                   busy_q;
  logic                   rd_pend_q;
  logic [c_lw-1:0]        rd_lane_q;

  logic                   w_col_clr;
  logic                   w_col_inc;
  logic                   w_load;
  logic                   w_is_img;
  logic                   w_last_col;
  logic                   w_rows_done;
  logic [c_cw-1:0]        w_col;
  logic [c_rw-1:0]        w_row;

  assign w_load    = (state_q == LOAD);
  assign w_col_clr = (state_q == IDLE) && start && en;
  assign w_col_inc = (state_q == SHOW) && col_rdy && !w_last_col;

  col_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW),
    .CW    (c_cw),
    .RW    (c_rw)
  ) u_addr (
    .PEclk         (PEclk),
    .rst_n         (rst_n),
    .en_i          (en),
    .load_i        (w_load),
    .p_i           (p_q),
    .col_clr_i     (w_col_clr),
    .col_inc_i     (w_col_inc),
    .col_o         (w_col),
    .row_o         (w_row),
    .is_img_o      (w_is_img),
    .last_col_o    (w_last_col),
    .rows_done_o   (w_rows_done),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr)
  );

  // Remember which lane each in-flight read belongs to; the return lands one cycle later
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_lane_q <= '0;
    end else begin
      rd_pend_q <= mem_rd_en;
      rd_lane_q <= c_lw'(p_q) + c_lw'(w_row);
    end
  end

  // Frame sequencer, lane assembly and PE-side handshake with registered outputs
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      pv_q          <= '0;
      col_data_q    <= '0;
      col_vld_q     <= 1'b0;
      frame_last_q  <= 1'b0;
      buf_release_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && en) begin
            p_q     <= clamp_pad(pad_len, PAD_MAX);
            pv_q    <= pad_value;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!w_is_img) begin
            if (en) begin
              col_data_q   <= {c_lanes{pv_q}};
              col_vld_q    <= 1'b1;
              frame_last_q <= w_last_col;
              state_q      <= SHOW;
            end
          end else begin
            // Nothing has been read for this column yet, so presetting is safe
            if (w_row == '0) col_data_q <= {c_lanes{pv_q}};
            if (en && w_rows_done) begin
              col_vld_q    <= 1'b1;
              frame_last_q <= w_last_col;
              state_q      <= SHOW;
            end
          end
        end
        SHOW: begin
          if (col_rdy) begin
            col_vld_q    <= 1'b0;
            frame_last_q <= 1'b0;
            if (w_last_col) begin
              buf_release_q <= 1'b1;
              state_q       <= REL;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        REL: begin
          // The release pulse is always exactly one cycle wide, independent of en
          buf_release_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Read returns are captured even while en is low
      for (int k = 0; k < c_lanes; k++) begin
        if (rd_pend_q && (rd_lane_q == c_lw'(k))) col_data_q[k*DW +: DW] <= mem_rd_data;
      end
    end
  end

  assign col_data    = col_data_q;
  assign col_vld     = col_vld_q;
  assign col_idx     = w_col;
  assign frame_last  = frame_last_q;
  assign buf_release = buf_release_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_padded_column_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_padded_column_streamer
//  Description : Self-checking bench for padded_column_streamer on a 4x3
//                frame with a 2-pixel maximum border.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_padded_column_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PM = 2;
  localparam int LN = H + 2 * PM;

  logic               PEclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         pad_len = 2'd0;
  logic [7:0]         pad_value = 8'd0;
  logic               mem_rd_en;
  logic [15:0]        mem_rd_addr;
  logic [7:0]         mem_rd_data = 8'd0;
  logic [LN*8-1:0]    col_data;
  logic               col_vld;
  logic               col_rdy = 1'b0;
  logic [3:0]         col_idx;
  logic               frame_last;
  logic               buf_release;
  logic               busy;

  int                 vectors = 0;
  int                 miscompares = 0;
  int                 rel_count = 0;
  logic [15:0]        rd_log[$];
  logic [7:0]         mem[0:W*H-1];

  padded_column_streamer #(
    .IMG_W(W), .IMG_H(H), .DW(8), .PAD_MAX(PM), .AW(16)
  ) dut (
    .PEclk(PEclk), .rst_n(rst_n), .en(en), .start(start),
    .pad_len(pad_len), .pad_value(pad_value),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .col_data(col_data), .col_vld(col_vld), .col_rdy(col_rdy), .col_idx(col_idx),
    .frame_last(frame_last), .buf_release(buf_release), .busy(busy)
  );

  always #5 PEclk = ~PEclk;

  // Buffer model: one-cycle read latency; also logs reads and release pulses
  always @(posedge PEclk) begin
    if (mem_rd_en) begin
      if (int'(mem_rd_addr) < W * H) mem_rd_data <= mem[mem_rd_addr[3:0]];
      else mem_rd_data <= 'x;
      rd_log.push_back(mem_rd_addr);
    end
    if (buf_release) rel_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference column: border of pv everywhere except the stored image placed at (p,p)
  function automatic logic [LN*8-1:0] exp_col(input int c, input int p, input logic [7:0] pv);
    logic [LN*8-1:0] v;
    for (int k = 0; k < LN; k++) begin
      if (c >= p && c < W + p && k >= p && k < p + H) v[k*8 +: 8] = mem[(k - p) * W + (c - p)];
      else v[k*8 +: 8] = pv;
    end
    return v;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 stall column 2 for five cycles
  task automatic run_frame(input logic [1:0] plen, input logic [7:0] pv, input int rdy_mode,
                           input int stall_at, input bit restart_mid);
    int p, nc, ncols, first_vld, held;
    bit done, hold_prev, rdy;
    logic [LN*8-1:0] prev_data;
    logic [3:0] prev_idx;
    logic [15:0] exp_rd[$];
    p = (int'(plen) > PM) ? PM : int'(plen);
    nc = W + 2 * p;
    ncols = 0; first_vld = -1; held = 0; done = 0; hold_prev = 0;
    prev_data = '0; prev_idx = '0;
    rel_count = 0;
    rd_log.delete();
    @(negedge PEclk);
    start = 1'b1; pad_len = plen; pad_value = pv; en = 1'b1;
    @(negedge PEclk);
    pad_len = 2'($urandom); pad_value = 8'($urandom);
    check("busy_after_start", busy, 1);
    for (int idx = 0; idx < 400 && !done; idx++) begin
      en    = !(stall_at >= 0 && (idx == stall_at || idx == stall_at + 1));
      start = (restart_mid && idx == 3);
      if (hold_prev) begin
        check("hold_vld", col_vld, 1);
        check("hold_data", col_data, prev_data);
        check("hold_idx", col_idx, prev_idx);
        check("hold_noread", mem_rd_en, 0);
      end
      if (col_vld && first_vld < 0) first_vld = idx;
      case (rdy_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = 1'b1;
          if (col_vld && col_idx == 4'd2 && held < 5) begin rdy = 1'b0; held++; end
        end
      endcase
      col_rdy = rdy;
      if (col_vld && rdy) begin
        check("col_data", col_data, exp_col(ncols, p, pv));
        check("col_idx", col_idx, ncols);
        check("frame_last", frame_last, (ncols == nc - 1));
        ncols++;
        hold_prev = 1'b0;
      end else begin
        hold_prev = col_vld;
      end
      prev_data = col_data;
      prev_idx  = col_idx;
      if (buf_release) begin
        check("release_after_last", ncols, nc);
        @(negedge PEclk);
        start = 1'b0;
        check("busy_after_rel", busy, 0);
        check("release_width", buf_release, 0);
        done = 1'b1;
      end else begin
        @(negedge PEclk);
      end
    end
    start = 1'b0; col_rdy = 1'b0; en = 1'b1;
    check("frame_timeout", done, 1);
    check("ncols", ncols, nc);
    check("release_count", rel_count, 1);
    if (stall_at < 0) check("first_vld_latency", first_vld, (p == 0) ? H + 1 : 1);
    for (int s = 0; s < W; s++)
      for (int r = 0; r < H; r++) exp_rd.push_back(16'(r * W + s));
    check("rd_count", rd_log.size(), W * H);
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) check("rd_addr", rd_log[i], exp_rd[i]);
  endtask

  initial begin
    for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
    repeat (3) @(negedge PEclk);
    check("rst_col_vld", col_vld, 0);
    check("rst_col_data", col_data, 0);
    check("rst_busy", busy, 0);
    check("rst_buf_release", buf_release, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    rst_n = 1'b1;

    run_frame(2'd1, 8'hEE, 0, -1, 0);
    run_frame(2'd0, 8'hEE, 0, -1, 0);
    run_frame(2'd3, 8'h3C, 0, -1, 0);
    run_frame(2'd1, 8'h77, 2, -1, 0);
    run_frame(2'd0, 8'hEE, 0, 1, 0);
    run_frame(2'd2, 8'h91, 0, -1, 1);

    // Reset in the middle of an image column read
    rel_count = 0;
    @(negedge PEclk);
    start = 1'b1; pad_len = 2'd1; pad_value = 8'h5A; en = 1'b1; col_rdy = 1'b1;
    @(negedge PEclk);
    start = 1'b0;
    repeat (3) @(negedge PEclk);
    rst_n = 1'b0;
    #1;
    check("midrst_col_vld", col_vld, 0);
    check("midrst_col_data", col_data, 0);
    check("midrst_col_idx", col_idx, 0);
    check("midrst_frame_last", frame_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem_rd_en", mem_rd_en, 0);
    check("midrst_mem_rd_addr", mem_rd_addr, 0);
    repeat (3) @(negedge PEclk);
    rst_n = 1'b1;
    col_rdy = 1'b0;
    repeat (3) @(negedge PEclk);
    check("midrst_no_release", rel_count, 0);
    check("midrst_idle", busy, 0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 1,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
